// File: rtl/kp_conv3x3.sv
// kp_conv3x3: runtime-programmable 3x3 convolution with double-buffered
// signed coefficients, round-half-up normalisation, optional absolute value
// and unsigned saturation. Fixed 4-cycle latency, no backpressure.
module kp_conv3x3 #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEF_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [3*DATA_WIDTH-1:0] i_r0_data,
  input  logic [3*DATA_WIDTH-1:0] i_r1_data,
  input  logic [3*DATA_WIDTH-1:0] i_r2_data,
  input  logic                    i_valid,
  input  logic                    i_cfg_wr,
  input  logic [3:0]              i_cfg_addr,
  input  logic [COEF_WIDTH-1:0]   i_cfg_data,
  input  logic                    i_cfg_commit,
  output logic                    o_cfg_pending,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;  // product width
  localparam int SUMW = DATA_WIDTH + COEF_WIDTH + 5;  // 9-term sum width
  localparam int EW = SUMW + 1;  // headroom for the rounding add
  localparam logic signed [EW-1:0] PIX_MAX = EW'((1 << DATA_WIDTH) - 1);

  // Default kernel (Gaussian 1-2-1) used at reset for both banks.
  function automatic logic [COEF_WIDTH-1:0] gauss_coef(input int k);
    logic [COEF_WIDTH-1:0] c;
    case (k)
      4:          c = COEF_WIDTH'(4);
      1, 3, 5, 7: c = COEF_WIDTH'(2);
      default:    c = COEF_WIDTH'(1);
    endcase
    return c;
  endfunction

  // Configuration banks
  logic [COEF_WIDTH-1:0]  coef_sh_r  [9];
  logic [COEF_WIDTH-1:0]  coef_act_r [9];
  logic [SHIFT_WIDTH-1:0] shift_sh_r, shift_act_r;
  logic                   abs_sh_r, abs_act_r;
  logic                   pending_r;
  logic                   cfg_hit_s;

  // Pipeline state
  logic [DATA_WIDTH-1:0]  pix_s   [9];
  logic signed [PW-1:0]   prod_s  [9];
  logic signed [PW-1:0]   prod1_r [9];
  logic signed [PW-1:0]   prod2_r [9];
  logic signed [SUMW-1:0] sum_s, sum3_r;
  logic [SHIFT_WIDTH-1:0] shift1_r, shift2_r, shift3_r;
  logic                   abs1_r, abs2_r, abs3_r;
  logic                   v1_r, v2_r, v3_r, v4_r;
  logic signed [EW-1:0]   ext_s, rnd_s, rsum_s, shr_s, mag_s;
  logic [DATA_WIDTH-1:0]  pix_next_s, data_r;

  // Only addresses 0..9 are real registers; 10..15 are silently ignored.
  assign cfg_hit_s = i_cfg_wr && (i_cfg_addr <= 4'd9);

  // Shadow/active config banks; commit copies the pre-write shadow because
  // both updates are non-blocking at the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < 9; k++) begin
        coef_sh_r[k]  <= gauss_coef(k);
        coef_act_r[k] <= gauss_coef(k);
      end
      shift_sh_r  <= SHIFT_WIDTH'(4);
      shift_act_r <= SHIFT_WIDTH'(4);
      abs_sh_r    <= 1'b0;
      abs_act_r   <= 1'b0;
      pending_r   <= 1'b0;
    end else begin
      if (i_cfg_commit) begin
        for (int k = 0; k < 9; k++) coef_act_r[k] <= coef_sh_r[k];
        shift_act_r <= shift_sh_r;
        abs_act_r   <= abs_sh_r;
      end
      if (i_cfg_wr) begin
        for (int k = 0; k < 9; k++) begin
          if (i_cfg_addr == 4'(k)) coef_sh_r[k] <= i_cfg_data;
        end
        if (i_cfg_addr == 4'd9) begin
          shift_sh_r <= i_cfg_data[SHIFT_WIDTH-1:0];
          abs_sh_r   <= i_cfg_data[SHIFT_WIDTH];
        end
      end
      if (cfg_hit_s) begin
        pending_r <= 1'b1;
      end else if (i_cfg_commit) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Unpack the window and form signed products against the active kernel.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      pix_s[j]     = i_r0_data[j*DATA_WIDTH +: DATA_WIDTH];
      pix_s[3 + j] = i_r1_data[j*DATA_WIDTH +: DATA_WIDTH];
      pix_s[6 + j] = i_r2_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int k = 0; k < 9; k++) begin
      prod_s[k] = PW'($signed(coef_act_r[k])) * PW'($signed({1'b0, pix_s[k]}));
    end
  end

  // Nine-term signed sum; the width leaves room for every extreme case.
  always_comb begin
    sum_s = {SUMW{1'b0}};
    for (int k = 0; k < 9; k++) begin
      sum_s = sum_s + SUMW'(prod2_r[k]);
    end
  end

  // Round half up, arithmetic shift, optional magnitude, then clamp to pixel range.
  always_comb begin
    ext_s = EW'(sum3_r);
    if (shift3_r != {SHIFT_WIDTH{1'b0}}) begin
      rnd_s = EW'(1) <<< (shift3_r - SHIFT_WIDTH'(1));
    end else begin
      rnd_s = {EW{1'b0}};
    end
    rsum_s = ext_s + rnd_s;
    shr_s  = rsum_s >>> shift3_r;
    if (abs3_r && shr_s[EW-1]) begin
      mag_s = -shr_s;
    end else begin
      mag_s = shr_s;
    end
    if (mag_s[EW-1]) begin
      pix_next_s = {DATA_WIDTH{1'b0}};
    end else if (mag_s > PIX_MAX) begin
      pix_next_s = {DATA_WIDTH{1'b1}};
    end else begin
      pix_next_s = mag_s[DATA_WIDTH-1:0];
    end
  end

  // Valid shift register; reset drops every in-flight sample.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
      v4_r <= 1'b0;
    end else begin
      v1_r <= i_valid;
      v2_r <= v1_r;
      v3_r <= v2_r;
      v4_r <= v3_r;
    end
  end

  // Datapath stages; shift/abs travel with each sample so configs never mix.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < 9; k++) begin
        prod1_r[k] <= {PW{1'b0}};
        prod2_r[k] <= {PW{1'b0}};
      end
      shift1_r <= {SHIFT_WIDTH{1'b0}};
      shift2_r <= {SHIFT_WIDTH{1'b0}};
      shift3_r <= {SHIFT_WIDTH{1'b0}};
      abs1_r   <= 1'b0;
      abs2_r   <= 1'b0;
      abs3_r   <= 1'b0;
      sum3_r   <= {SUMW{1'b0}};
      data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int k = 0; k < 9; k++) begin
        prod1_r[k] <= prod_s[k];
        prod2_r[k] <= prod1_r[k];
      end
      shift1_r <= shift_act_r;
      shift2_r <= shift1_r;
      shift3_r <= shift2_r;
      abs1_r   <= abs_act_r;
      abs2_r   <= abs1_r;
      abs3_r   <= abs2_r;
      sum3_r   <= sum_s;
      data_r   <= pix_next_s;
    end
  end

  assign o_data        = data_r;
  assign o_valid       = v4_r;
  assign o_cfg_pending = pending_r;

endmodule

// File: tb/tb_kp_conv3x3.sv
// Self-checking bench for kp_conv3x3: table of kernel/pixel vectors plus
// hand-written sequences for commit timing and reset; results are matched
// through a scoreboard that also checks the 4-cycle latency.
module tb_kp_conv3x3;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [23:0] i_r0_data = 24'd0, i_r1_data = 24'd0, i_r2_data = 24'd0;
  logic        i_valid = 1'b0;
  logic        i_cfg_wr = 1'b0;
  logic [3:0]  i_cfg_addr = 4'd0;
  logic [7:0]  i_cfg_data = 8'd0;
  logic        i_cfg_commit = 1'b0;
  logic        o_cfg_pending;
  logic [7:0]  o_data;
  logic        o_valid;

  kp_conv3x3 dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_r0_data(i_r0_data), .i_r1_data(i_r1_data), .i_r2_data(i_r2_data),
    .i_valid(i_valid), .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data), .i_cfg_commit(i_cfg_commit),
    .o_cfg_pending(o_cfg_pending), .o_data(o_data), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef int coef9_t[9];
  typedef struct {
    string  name;
    coef9_t coef;
    int     shift;
    bit     abs_en;
    int     p0, p1, p2;
    int     exp;
  } vec_t;
  typedef struct {
    string name;
    int    exp;
    int    due;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: every o_valid must match the oldest outstanding sample.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        sb_t s;
        s = sb_q.pop_front();
        check({s.name, "_latency"}, cyc, s.due);
        check({s.name, "_data"}, int'(o_data), s.exp);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_pix(input int p0, input int p1, input int p2);
    logic [23:0] row;
    row = {8'(p2), 8'(p1), 8'(p0)};
    i_r0_data = row;
    i_r1_data = row;
    i_r2_data = row;
  endtask

  task automatic cfg_write(input int addr, input int data);
    i_cfg_wr   = 1'b1;
    i_cfg_addr = 4'(addr);
    i_cfg_data = 8'(data);
    step();
    i_cfg_wr = 1'b0;
  endtask

  task automatic commit();
    i_cfg_commit = 1'b1;
    step();
    i_cfg_commit = 1'b0;
  endtask

  task automatic send(input int p0, input int p1, input int p2, input int exp, input string name);
    set_pix(p0, p1, p2);
    i_valid = 1'b1;
    sb_q.push_back('{name, exp, cyc + 4});
    step();
    i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (8) step();
    check({name, "_drain"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic load_kernel(input coef9_t c, input int sh, input bit ab);
    for (int k = 0; k < 9; k++) cfg_write(k, c[k]);
    cfg_write(9, (int'(ab) << 4) | sh);
  endtask

  function automatic vec_t mk(input string n, input coef9_t c, input int sh, input bit ab,
                              input int p0, input int p1, input int p2, input int e);
    vec_t v;
    v.name = n; v.coef = c; v.shift = sh; v.abs_en = ab;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.exp = e;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    coef9_t gauss, ones, twos, sobel, fours, one0, m3_0, c127, cm128;
    gauss = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    ones  = '{default: 1};
    twos  = '{default: 2};
    sobel = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    fours = '{default: 4};
    one0  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    m3_0  = '{-3, 0, 0, 0, 0, 0, 0, 0, 0};
    c127  = '{default: 127};
    cm128 = '{default: -128};

    vecs[0] = mk("gauss_loaded", gauss, 4, 1'b0, 100, 100, 100, 100);
    vecs[1] = mk("box_round",    ones,  4, 1'b0,   8,   8,   8,   5);
    vecs[2] = mk("sobel_pos",    sobel, 0, 1'b0,  10,  77,  50, 160);
    vecs[3] = mk("sobel_neg",    sobel, 0, 1'b0,  50,  77,  10,   0);
    vecs[4] = mk("sobel_abs",    sobel, 0, 1'b1,  50,  77,  10, 160);
    vecs[5] = mk("saturate",     fours, 0, 1'b0, 255, 255, 255, 255);
    vecs[6] = mk("shift0_sum",   ones,  0, 1'b0,   3,   5,   7,  45);
    vecs[7] = mk("half_up",      one0,  4, 1'b0,   8,   0,   0,   1);
    vecs[8] = mk("neg_round_abs", m3_0, 4, 1'b1,   8,   0,   0,   1);
    vecs[9] = mk("shift_max",    c127, 15, 1'b0, 255, 255, 255,   9);

    // Reset state
    repeat (3) step();
    check("rst_valid", int'(o_valid), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_pending", int'(o_cfg_pending), 0);
    i_rstn = 1'b1;
    step();
    send(100, 100, 100, 100, "gauss_reset");
    drain("gauss_reset");

    // Table-driven kernels
    for (int i = 0; i < 10; i++) begin
      load_kernel(vecs[i].coef, vecs[i].shift, vecs[i].abs_en);
      check({vecs[i].name, "_pending_set"}, int'(o_cfg_pending), 1);
      commit();
      check({vecs[i].name, "_pending_clr"}, int'(o_cfg_pending), 0);
      send(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].exp, vecs[i].name);
      drain(vecs[i].name);
    end
    // Most negative kernel: floor(-277376/32768) = -9, magnitude 9
    load_kernel(cm128, 15, 1'b1);
    commit();
    send(255, 255, 255, 9, "neg_max_abs");
    drain("neg_max_abs");

    // Commit in the middle of an unbroken stream
    load_kernel(ones, 0, 1'b0);
    commit();
    load_kernel(twos, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      set_pix(i + 1, i + 1, i + 1);
      i_valid = 1'b1;
      i_cfg_commit = (i == 2);
      if (i == 2) check("stream_pending_before", int'(o_cfg_pending), 1);
      sb_q.push_back('{"stream", (i <= 2) ? 9 * (i + 1) : 18 * (i + 1), cyc + 4});
      step();
      if (i == 2) check("stream_pending_after", int'(o_cfg_pending), 0);
    end
    i_valid = 1'b0;
    i_cfg_commit = 1'b0;
    drain("stream");

    // Write and commit in the same cycle
    i_cfg_wr = 1'b1;
    i_cfg_addr = 4'd0;
    i_cfg_data = 8'd5;
    i_cfg_commit = 1'b1;
    step();
    i_cfg_wr = 1'b0;
    i_cfg_commit = 1'b0;
    check("wrcommit_pending", int'(o_cfg_pending), 1);
    send(1, 1, 1, 18, "wrcommit_old");
    drain("wrcommit_old");
    commit();
    check("wrcommit_pending_clr", int'(o_cfg_pending), 0);
    send(1, 1, 1, 21, "wrcommit_new");
    drain("wrcommit_new");

    // Ignored addresses and an empty commit
    cfg_write(12, 127);
    cfg_write(15, 3);
    check("ignored_addr_pending", int'(o_cfg_pending), 0);
    commit();
    check("empty_commit_pending", int'(o_cfg_pending), 0);
    send(1, 1, 1, 21, "after_ignored");
    drain("after_ignored");

    // Reset with three samples in flight and an uncommitted shadow write
    cfg_write(0, 9);
    set_pix(100, 100, 100);
    i_valid = 1'b1;
    repeat (3) step();
    i_valid = 1'b0;
    i_rstn = 1'b0;
    repeat (2) step();
    i_rstn = 1'b1;
    check("midrst_pending", int'(o_cfg_pending), 0);
    repeat (8) step();
    send(100, 100, 100, 100, "midrst_active");
    drain("midrst_active");
    commit();
    send(100, 100, 100, 100, "midrst_shadow");
    drain("midrst_shadow");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
